rmii_rx_capture: RTL

//  Multi-bank RMII receive frame capture. Takes the 2-bit RMII RX stream, strips preamble/SFD,

---
 rtl/rmii_rx_capture.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/rmii_rx_capture.sv
`default_nettype none
// ============================================================================
//  Module      : rmii_rx_capture
//  Description : RMII receive capture. Strips preamble/SFD, assembles bytes
//                LSB-first and stores a per-frame byte window into one of
//                2**BANKS_LOG2 banks, with per-frame status reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module rmii_rx_capture #(
    parameter int BYTES_LOG2 = 6,
    parameter int BANKS_LOG2 = 1,
    parameter int SKIP_W     = 11,
    localparam int c_BANK_W  = (BANKS_LOG2 > 0) ? BANKS_LOG2 : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rmii_crs,
    input  logic [1:0]            rmii_rx,
    input  logic [SKIP_W-1:0]     skip_bytes,
    input  logic                  single_shot,
    input  logic                  arm,
    input  logic [c_BANK_W-1:0]   rd_bank,
    input  logic [BYTES_LOG2-1:0] rd_addr,
    output logic [7:0]            rd_data,
    output logic                  frame_done,
    output logic [c_BANK_W-1:0]   frame_bank,
    output logic [15:0]           frame_len,
    output logic                  frame_odd,
    output logic                  frozen,
    output logic [7:0]            drop_cnt
);

    localparam int          c_ADDR_W  = BYTES_LOG2 + BANKS_LOG2;
    localparam int          c_DEPTH   = 2 ** c_ADDR_W;
    localparam logic [16:0] c_WIN     = 17'(2 ** BYTES_LOG2);

    localparam logic [2:0]  c_ST_IDLE = 3'd0;
    localparam logic [2:0]  c_ST_PRE  = 3'd1;
    localparam logic [2:0]  c_ST_DATA = 3'd2;
    localparam logic [2:0]  c_ST_END  = 3'd3;
    localparam logic [2:0]  c_ST_DROP = 3'd4;

    logic [2:0]            r_state;
    logic [1:0]            r_phase;
    logic [5:0]            r_byte;
    logic [15:0]           r_byte_cnt;
    logic [SKIP_W-1:0]     r_skip;
    logic                  r_capture;
    logic                  r_idle_ok;
    logic [c_BANK_W-1:0]   r_wbank;
    logic                  r_frame_done;
    logic [c_BANK_W-1:0]   r_frame_bank;
    logic [15:0]           r_frame_len;
    logic                  r_frame_odd;
    logic                  r_frozen;
    logic [7:0]            r_drop_cnt;
    logic [7:0]            r_rd_data;
    logic [7:0]            r_mem [0:c_DEPTH-1];

    logic [7:0]            w_byte;
    logic [16:0]           w_idx;
    logic                  w_in_win;
    logic                  w_we;
    logic [c_ADDR_W-1:0]   w_wr_addr;
    logic [c_ADDR_W-1:0]   w_rd_addr;
    logic [c_BANK_W-1:0]   w_next_bank;

    assign w_byte   = {rmii_rx, r_byte};
    assign w_idx    = {1'b0, r_byte_cnt} - 17'(r_skip);
    // A borrow out of the subtraction means the byte is still in the skip region
    assign w_in_win = !w_idx[16] && (w_idx < c_WIN);
    assign w_we     = (r_state == c_ST_DATA) && rmii_crs && (r_phase == 2'd3)
                      && r_capture && w_in_win;

    generate
        if (BANKS_LOG2 == 0) begin : g_one_bank
            assign w_wr_addr   = w_idx[BYTES_LOG2-1:0];
            assign w_rd_addr   = rd_addr;
            assign w_next_bank = '0;
        end else begin : g_multi_bank
            assign w_wr_addr   = {r_wbank, w_idx[BYTES_LOG2-1:0]};
            assign w_rd_addr   = {rd_bank, rd_addr};
            assign w_next_bank = r_wbank + 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_wr_addr] <= w_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= 8'd0;
        end else begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_phase      <= 2'd0;
            r_byte       <= 6'd0;
            r_byte_cnt   <= 16'd0;
            r_skip       <= '0;
            r_capture    <= 1'b0;
            r_idle_ok    <= 1'b0;
            r_wbank      <= '0;
            r_frame_done <= 1'b0;
            r_frame_bank <= '0;
            r_frame_len  <= 16'd0;
            r_frame_odd  <= 1'b0;
            r_frozen     <= 1'b0;
            r_drop_cnt   <= 8'd0;
        end else begin
            r_frame_done <= 1'b0;
            // A frame cut by reset must not be re-synchronised on its payload
            if (!rmii_crs) begin
                r_idle_ok <= 1'b1;
            end
            if (!single_shot || arm) begin
                r_frozen <= 1'b0;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (rmii_crs && (rmii_rx == 2'b01) && r_idle_ok) begin
                        r_state <= c_ST_PRE;
                    end
                end
                c_ST_PRE: begin
                    if (!rmii_crs) begin
                        r_state <= c_ST_IDLE;
                    end else if (rmii_rx == 2'b11) begin
                        r_state    <= c_ST_DATA;
                        r_skip     <= skip_bytes;
                        r_byte_cnt <= 16'd0;
                        r_phase    <= 2'd0;
                        r_capture  <= !(r_frozen && single_shot);
                    end else if (rmii_rx != 2'b01) begin
                        r_state <= c_ST_DROP;
                    end
                end
                c_ST_DATA: begin
                    if (!rmii_crs) begin
                        r_state <= c_ST_END;
                    end else begin
                        r_phase <= r_phase + 2'd1;
                        if (r_phase == 2'd3) begin
                            if (r_byte_cnt != 16'hFFFF) begin
                                r_byte_cnt <= r_byte_cnt + 16'd1;
                            end
                        end else begin
                            r_byte[{r_phase, 1'b0} +: 2] <= rmii_rx;
                        end
                    end
                end
                c_ST_END: begin
                    r_state <= c_ST_IDLE;
                    if (r_capture) begin
                        r_frame_done <= 1'b1;
                        r_frame_len  <= r_byte_cnt;
                        r_frame_odd  <= (r_phase != 2'd0);
                        r_frame_bank <= r_wbank;
                        if (single_shot) begin
                            r_frozen <= 1'b1;
                        end else begin
                            r_wbank <= w_next_bank;
                        end
                    end else if (r_drop_cnt != 8'hFF) begin
                        r_drop_cnt <= r_drop_cnt + 8'd1;
                    end
                end
                c_ST_DROP: begin
                    if (!rmii_crs) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign rd_data    = r_rd_data;
    assign frame_done = r_frame_done;
    assign frame_bank = r_frame_bank;
    assign frame_len  = r_frame_len;
    assign frame_odd  = r_frame_odd;
    assign frozen     = r_frozen;
    assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire
